// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - memory/decode handshake bundle for the multicycle sequencer
interface multicycle_sequencer_if #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
);
  // instruction memory side
  logic [XLEN-1:0]     inst_add;
  logic                inst_req;
  logic                inst_ready;
  logic [31:0]         inst_data;
  // decode / execute side
  logic [31:0]         instruction;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     pc_4;
  logic [XLEN-1:0]     next_pc;
  logic                illegal;
  logic                mem_access;
  logic                reg_write_req;
  // data memory side
  logic                data_req;
  logic                data_ready;
  // write-back, trap and status
  logic                reg_write_en;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [RETIRE_W-1:0] retired;
  logic                halt_req;
  logic                halted;

  // sequencer side
  modport master (
    output inst_add, inst_req, instruction, pc, pc_4, data_req,
           reg_write_en, trap, trap_cause, retired, halted,
    input  inst_ready, inst_data, next_pc, illegal, mem_access,
           reg_write_req, data_ready, halt_req
  );

  // memories / datapath side
  modport slave (
    input  inst_add, inst_req, instruction, pc, pc_4, data_req,
           reg_write_en, trap, trap_cause, retired, halted,
    output inst_ready, inst_data, next_pc, illegal, mem_access,
           reg_write_req, data_ready, halt_req
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module multicycle_sequencer #(
  parameter int                   XLEN           = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR   = '0,
  parameter logic [XLEN-1:0]      TRAP_VECTOR    = XLEN'('h100),
  parameter int unsigned          TIMEOUT_CYCLES = 16,
  parameter int                   RETIRE_W       = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP,
    S_HALT
  } state_t;

  localparam logic [31:0] LP_NOP       = 32'h0000_0013;
  localparam bit          LP_TO_EN     = (TIMEOUT_CYCLES != 0);
  // Counter value seen in request cycle number TIMEOUT_CYCLES (counter starts at 0).
  localparam logic [31:0] LP_WAIT_LAST = LP_TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  localparam logic [1:0]  LP_CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0]  LP_CAUSE_FETCH   = 2'd2;
  localparam logic [1:0]  LP_CAUSE_DATA    = 2'd3;

  state_t               r_state;
  logic [XLEN-1:0]      r_pc;
  logic [31:0]          r_ir;
  logic [31:0]          r_wait;
  logic [1:0]           r_trap_cause;
  logic [RETIRE_W-1:0]  r_retired;
  logic                 r_inst_req;
  logic                 r_data_req;
  logic                 r_reg_write_en;
  logic                 r_trap;
  logic                 r_halted;

  logic                 w_wait_expired;

  // A stalled access gives up when the last permitted request cycle also lacks ready.
  assign w_wait_expired = LP_TO_EN && (r_wait == LP_WAIT_LAST);

  // Sequencer FSM; every strobe is set on the edge entering the state that owns it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_VECTOR;
      r_ir           <= LP_NOP;
      r_wait         <= 32'd0;
      r_trap_cause   <= 2'd0;
      r_retired      <= '0;
      r_inst_req     <= 1'b0;
      r_data_req     <= 1'b0;
      r_reg_write_en <= 1'b0;
      r_trap         <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_inst_req     <= 1'b0;
      r_data_req     <= 1'b0;
      r_reg_write_en <= 1'b0;
      r_trap         <= 1'b0;
      r_halted       <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state    <= S_FETCH;
          r_inst_req <= 1'b1;
          r_wait     <= 32'd0;
        end
        S_FETCH: begin
          if (bus.inst_ready) begin
            r_ir    <= bus.inst_data;
            r_state <= S_DECODE;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= LP_CAUSE_FETCH;
          end else begin
            r_wait     <= r_wait + 32'd1;
            r_inst_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (bus.illegal) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= LP_CAUSE_ILLEGAL;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (bus.mem_access) begin
            r_state    <= S_MEMORY;
            r_data_req <= 1'b1;
            r_wait     <= 32'd0;
          end else begin
            // reg_write_req is decoded from the stable IR, so it is valid one cycle early
            r_state        <= S_WRITEBACK;
            r_reg_write_en <= bus.reg_write_req;
          end
        end
        S_MEMORY: begin
          if (bus.data_ready) begin
            r_state        <= S_WRITEBACK;
            r_reg_write_en <= bus.reg_write_req;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= LP_CAUSE_DATA;
          end else begin
            r_wait     <= r_wait + 32'd1;
            r_data_req <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_pc      <= bus.next_pc;
          r_retired <= r_retired + RETIRE_W'(1);
          if (bus.halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_inst_req <= 1'b1;
            r_wait     <= 32'd0;
          end
        end
        S_TRAP: begin
          // PC keeps the faulting address during the trap cycle, then vectors
          r_pc       <= TRAP_VECTOR;
          r_state    <= S_FETCH;
          r_inst_req <= 1'b1;
          r_wait     <= 32'd0;
        end
        S_HALT: begin
          if (bus.halt_req) begin
            r_halted <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_inst_req <= 1'b1;
            r_wait     <= 32'd0;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.inst_add     = r_pc;
  assign bus.pc           = r_pc;
  assign bus.pc_4         = r_pc + XLEN'(4);
  assign bus.instruction  = r_ir;
  assign bus.inst_req     = r_inst_req;
  assign bus.data_req     = r_data_req;
  assign bus.reg_write_en = r_reg_write_en;
  assign bus.trap         = r_trap;
  assign bus.trap_cause   = r_trap_cause;
  assign bus.retired      = r_retired;
  assign bus.halted       = r_halted;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench with transaction-level reference model
module tb_multicycle_sequencer;

  localparam int          TO  = 16;
  localparam logic [31:0] TV  = 32'h100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_sequencer_if #(.XLEN(32), .RETIRE_W(32)) bus ();

  multicycle_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TV),
    .TIMEOUT_CYCLES(TO), .RETIRE_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] next_pc;
    logic        illegal;
    logic        mem_access;
    logic        reg_write_req;
    logic        data_ready;
    logic        halt_req;
  } stim_t;

  typedef struct {
    logic        inst_req;
    logic        data_req;
    logic        reg_write_en;
    logic        trap;
    logic        halted;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] retired;
    logic [1:0]  trap_cause;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // architectural view of the core, advanced one instruction at a time
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_ret;
  logic [1:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e.inst_req     = 1'b0;
    e.data_req     = 1'b0;
    e.reg_write_en = 1'b0;
    e.trap         = 1'b0;
    e.halted       = 1'b0;
    e.pc           = m_pc;
    e.instruction  = m_ir;
    e.retired      = m_ret;
    e.trap_cause   = m_cause;
    return e;
  endfunction

  // inputs that are not consumed in a cycle get random values
  function automatic stim_t noise();
    stim_t s;
    s.inst_ready    = 1'($urandom_range(0, 1));
    s.inst_data     = $urandom;
    s.next_pc       = $urandom;
    s.illegal       = 1'($urandom_range(0, 1));
    s.mem_access    = 1'($urandom_range(0, 1));
    s.reg_write_req = 1'($urandom_range(0, 1));
    s.data_ready    = 1'($urandom_range(0, 1));
    s.halt_req      = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_trap(input logic [1:0] cause);
    stim_t s;
    exp_t  e;
    s = noise();
    m_cause = cause;
    e = base();
    e.trap = 1'b1;
    push(s, e);
    m_pc = TV;
  endtask

  // Expand one instruction into its cycle-by-cycle stimulus and expected outputs.
  // fw/dw: not-ready cycles before ready (>= TO means timeout). hl: halt cycles (0 = no halt).
  task automatic add_instr(input int fw, input bit ill, input bit mem, input int dw, input bit rwr,
                           input logic [31:0] npc, input int hl, input logic [31:0] idata);
    stim_t s;
    exp_t  e;
    for (int k = 0; k < fw && k < TO; k++) begin
      s = noise(); s.inst_ready = 1'b0;
      e = base();  e.inst_req = 1'b1;
      push(s, e);
    end
    if (fw >= TO) begin
      add_trap(2'd2);
      return;
    end
    s = noise(); s.inst_ready = 1'b1; s.inst_data = idata;
    e = base();  e.inst_req = 1'b1;
    push(s, e);
    m_ir = idata;
    // decode
    s = noise(); s.illegal = ill; s.reg_write_req = rwr;
    e = base();
    push(s, e);
    if (ill) begin
      add_trap(2'd1);
      return;
    end
    // execute
    s = noise(); s.mem_access = mem; s.reg_write_req = rwr;
    e = base();
    push(s, e);
    if (mem) begin
      for (int k = 0; k < dw && k < TO; k++) begin
        s = noise(); s.data_ready = 1'b0; s.reg_write_req = rwr;
        e = base();  e.data_req = 1'b1;
        push(s, e);
      end
      if (dw >= TO) begin
        add_trap(2'd3);
        return;
      end
      s = noise(); s.data_ready = 1'b1; s.reg_write_req = rwr;
      e = base();  e.data_req = 1'b1;
      push(s, e);
    end
    // writeback
    s = noise(); s.next_pc = npc; s.halt_req = (hl > 0); s.reg_write_req = rwr;
    e = base();  e.reg_write_en = rwr;
    push(s, e);
    m_pc  = npc;
    m_ret = m_ret + 32'd1;
    for (int k = 1; k <= hl; k++) begin
      s = noise(); s.halt_req = (k < hl);
      e = base();  e.halted = 1'b1;
      push(s, e);
    end
  endtask

  task automatic apply(input stim_t s);
    bus.inst_ready    = s.inst_ready;
    bus.inst_data     = s.inst_data;
    bus.next_pc       = s.next_pc;
    bus.illegal       = s.illegal;
    bus.mem_access    = s.mem_access;
    bus.reg_write_req = s.reg_write_req;
    bus.data_ready    = s.data_ready;
    bus.halt_req      = s.halt_req;
  endtask

  task automatic compare(input int c);
    exp_t e;
    e = exp_q[c];
    chk("inst_req",     32'(bus.inst_req),     32'(e.inst_req),     c);
    chk("data_req",     32'(bus.data_req),     32'(e.data_req),     c);
    chk("reg_write_en", 32'(bus.reg_write_en), 32'(e.reg_write_en), c);
    chk("trap",         32'(bus.trap),         32'(e.trap),         c);
    chk("halted",       32'(bus.halted),       32'(e.halted),       c);
    chk("pc",           bus.pc,                e.pc,                c);
    chk("inst_add",     bus.inst_add,          e.pc,                c);
    chk("pc_4",         bus.pc_4,              e.pc + 32'd4,        c);
    chk("instruction",  bus.instruction,       e.instruction,       c);
    chk("retired",      bus.retired,           e.retired,           c);
    chk("trap_cause",   32'(bus.trap_cause),   32'(e.trap_cause),   c);
  endtask

  // hand-computed expectations for the directed opening sequence
  task automatic pin(input int c);
    case (c)
      0:  begin chk("lit_reset_ir", bus.instruction, NOP, c); chk("lit_reset_pc4", bus.pc_4, 32'h4, c);
                chk("lit_reset_inst_req", 32'(bus.inst_req), 32'd0, c); end
      1:  begin chk("lit_first_req", 32'(bus.inst_req), 32'd1, c); chk("lit_add0", bus.inst_add, 32'h0, c); end
      5:  chk("lit_add4", bus.inst_add, 32'h4, c);
      9:  chk("lit_add8", bus.inst_add, 32'h8, c);
      12: chk("lit_wb3", 32'(bus.reg_write_en), 32'd1, c);
      13: begin chk("lit_retired3", bus.retired, 32'd3, c); chk("lit_add12", bus.inst_add, 32'hc, c); end
      16: chk("lit_dreq_first", 32'(bus.data_req), 32'd1, c);
      19: chk("lit_dreq_last", 32'(bus.data_req), 32'd1, c);
      20: begin chk("lit_dreq_drop", 32'(bus.data_req), 32'd0, c); chk("lit_load_wb", 32'(bus.reg_write_en), 32'd1, c); end
      21: chk("lit_load_pc", bus.inst_add, 32'h10, c);
      36: chk("lit_req16", 32'(bus.inst_req), 32'd1, c);
      37: begin chk("lit_to_trap", 32'(bus.trap), 32'd1, c); chk("lit_to_cause", 32'(bus.trap_cause), 32'd2, c); end
      38: chk("lit_trap_vec", bus.inst_add, TV, c);
      default: ;
    endcase
  endtask

  initial begin
    int          fw, dw, hl;
    bit          ill, mem, rwr;
    logic [31:0] npc;
    bit          found;
    stim_t       s;

    m_pc = 32'h0; m_ir = NOP; m_ret = 32'd0; m_cause = 2'd0;
    s = noise();
    apply(s);

    // boot cycle
    push(noise(), base());
    // NOP stream
    for (int i = 0; i < 3; i++) add_instr(0, 0, 0, 0, 1, m_pc + 32'd4, 0, NOP);
    // load, data ready after 3 wait cycles
    add_instr(0, 0, 1, 3, 1, m_pc + 32'd4, 0, 32'h0000_2003);
    // fetch timeout
    add_instr(16, 0, 0, 0, 1, 32'h0, 0, NOP);
    // ready in the last allowed cycle, then jump to 8
    add_instr(15, 0, 0, 0, 1, 32'h8, 0, NOP);
    // illegal at pc 8
    add_instr(0, 1, 0, 0, 1, 32'h0, 0, 32'hffff_ffff);
    // jal to 0x40 with halt held for 3 cycles
    add_instr(0, 0, 0, 0, 1, 32'h40, 3, 32'h0400_006f);
    // pc_4 wrap at the top of the address space
    add_instr(0, 0, 0, 0, 0, 32'hffff_fffc, 0, NOP);
    add_instr(0, 0, 0, 0, 1, 32'h0, 0, NOP);
    // data timeout
    add_instr(0, 0, 1, 16, 1, 32'h0, 0, 32'h0000_2023);
    // random program
    for (int i = 0; i < 150; i++) begin
      fw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 3));
      dw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 3));
      ill = ($urandom_range(0, 11) == 0);
      mem = ($urandom_range(0, 2) == 0);
      rwr = 1'($urandom_range(0, 1));
      npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : (m_pc + 32'd4);
      hl  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      add_instr(fw, ill, mem, dw, rwr, npc, hl, $urandom);
    end

    // model pins
    chk("model_add8",   exp_q[9].pc, 32'h8, 9);
    chk("model_trap37", 32'(exp_q[37].trap), 32'd1, 37);
    chk("model_ret13",  exp_q[13].retired, 32'd3, 13);

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < stim_q.size(); c++) begin
      apply(stim_q[c]);
      @(negedge clock);
      compare(c);
      pin(c);
      @(posedge clock);
      #1;
    end

    // asynchronous reset during a data-memory wait
    bus.inst_ready = 1'b1; bus.illegal = 1'b0; bus.mem_access = 1'b1;
    bus.data_ready = 1'b0; bus.halt_req = 1'b0; bus.reg_write_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clock);
      if (bus.data_req === 1'b1) found = 1'b1;
    end
    chk("rst_reach_memory", 32'(found), 32'd1, -1);
    #1 reset = 1'b1;
    #1;
    chk("rst_data_req",     32'(bus.data_req),     32'd0, -1);
    chk("rst_inst_req",     32'(bus.inst_req),     32'd0, -1);
    chk("rst_reg_write_en", 32'(bus.reg_write_en), 32'd0, -1);
    chk("rst_trap",         32'(bus.trap),         32'd0, -1);
    chk("rst_halted",       32'(bus.halted),       32'd0, -1);
    chk("rst_pc",           bus.pc,                32'h0, -1);
    chk("rst_retired",      bus.retired,           32'd0, -1);
    chk("rst_trap_cause",   32'(bus.trap_cause),   32'd0, -1);
    chk("rst_ir",           bus.instruction,       NOP,   -1);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_boot_idle", 32'(bus.inst_req), 32'd0, -1);
    @(negedge clock);
    chk("rst_fetch_req", 32'(bus.inst_req), 32'd1, -1);
    chk("rst_fetch_add", bus.inst_add, 32'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
